// File: rtl/cmd_parser_pkg.sv
// Shared types and constants for the command-word parser.
// Holds the header layout, opcode set, expected payload lengths and parser state encoding.
package cmd_parser_pkg;

  localparam int cmd_buf_width_gp = 32;
  localparam int payload_words_c  = 3;

  localparam logic [7:0] fetch_len_c     = 8'd8;
  localparam logic [7:0] disp_len_c      = 8'd4;
  localparam logic [7:0] tile_len_c      = 8'd12;
  localparam logic [7:0] wait_disp_len_c = 8'd4;
  localparam logic [7:0] wait_tile_len_c = 8'd4;

  typedef enum logic [7:0] {
    op_fetch     = 8'hF0,
    op_disp      = 8'hF1,
    op_tile      = 8'hF2,
    op_wait_disp = 8'hF3,
    op_wait_tile = 8'hF4
  } cmd_op_s;

  typedef struct packed {
    logic [7:0] reserved;
    logic [7:0] len;
    logic [7:0] id;
    logic [7:0] op;
  } cmd_header_s;

  typedef enum logic [1:0] {
    err_none         = 2'd0,
    err_unknown_op   = 2'd1,
    err_len_mismatch = 2'd2
  } cmd_parse_err_e;

  typedef enum logic [1:0] {
    st_idle    = 2'd0,
    st_payload = 2'd1,
    st_emit    = 2'd2,
    st_drain   = 2'd3
  } parser_state_e;

  // Returns {known, expected_len}; known=0 for opcodes outside the command set.
  function automatic logic [8:0] expected_len(input logic [7:0] op);
    case (op)
      op_fetch:     return {1'b1, fetch_len_c};
      op_disp:      return {1'b1, disp_len_c};
      op_tile:      return {1'b1, tile_len_c};
      op_wait_disp: return {1'b1, wait_disp_len_c};
      op_wait_tile: return {1'b1, wait_tile_len_c};
      default:      return 9'd0;
    endcase
  endfunction

endpackage

// File: rtl/cmd_parser.sv
// Parses header + payload words from the command FIFO into decoded commands,
// flagging unknown opcodes and length mismatches and draining the offending payload.
module cmd_parser
  import cmd_parser_pkg::*;
(
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic                        word_v_i,
  input  logic [cmd_buf_width_gp-1:0] word_i,
  output logic                        word_ready_o,
  output logic                        cmd_v_o,
  input  logic                        cmd_ready_i,
  output logic [7:0]                  cmd_op_o,
  output logic [7:0]                  cmd_id_o,
  output logic [95:0]                 cmd_payload_o,
  output logic                        err_v_o,
  output logic [1:0]                  err_code_o,
  output logic [15:0]                 cmd_count_o,
  output logic [15:0]                 err_count_o
);

  parser_state_e  state_r;
  cmd_parse_err_e err_code_r;
  logic [6:0]     remain_r;
  logic [1:0]     slot_r;
  logic           word_ready_r;
  logic           cmd_v_r;
  logic           err_v_r;
  logic [7:0]     cmd_op_r;
  logic [7:0]     cmd_id_r;
  logic [95:0]    cmd_payload_r;
  logic [15:0]    cmd_count_r;
  logic [15:0]    err_count_r;

  cmd_header_s hdr_s;
  logic [8:0]  exp_s;
  logic        xfer_s;
  logic [6:0]  drain_words_s;
  logic        unused_reserved_s;

  assign hdr_s             = cmd_header_s'(word_i);
  assign exp_s             = expected_len(hdr_s.op);
  assign xfer_s            = word_v_i & word_ready_r;
  // Rejected headers discard ceil(len/4) words; len is in bytes.
  assign drain_words_s     = 7'(({1'b0, hdr_s.len} + 9'd3) >> 2);
  assign unused_reserved_s = ^hdr_s.reserved;

  // Parser FSM with all outputs and counters registered.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r       <= st_idle;
      err_code_r    <= err_none;
      remain_r      <= 7'd0;
      slot_r        <= 2'd0;
      word_ready_r  <= 1'b0;
      cmd_v_r       <= 1'b0;
      err_v_r       <= 1'b0;
      cmd_op_r      <= 8'd0;
      cmd_id_r      <= 8'd0;
      cmd_payload_r <= 96'd0;
      cmd_count_r   <= 16'd0;
      err_count_r   <= 16'd0;
    end else begin
      err_v_r    <= 1'b0;
      err_code_r <= err_none;
      case (state_r)
        st_idle: begin
          word_ready_r <= 1'b1;
          if (xfer_s) begin
            if (exp_s[8] && (exp_s[7:0] == hdr_s.len)) begin
              cmd_op_r      <= hdr_s.op;
              cmd_id_r      <= hdr_s.id;
              cmd_payload_r <= 96'd0;
              slot_r        <= 2'd0;
              remain_r      <= 7'(hdr_s.len >> 2);
              state_r       <= st_payload;
            end else begin
              err_v_r     <= 1'b1;
              err_count_r <= err_count_r + 16'd1;
              remain_r    <= drain_words_s;
              if (exp_s[8]) begin
                err_code_r <= err_len_mismatch;
              end else begin
                err_code_r <= err_unknown_op;
              end
              if (drain_words_s == 7'd0) begin
                state_r <= st_idle;
              end else begin
                state_r <= st_drain;
              end
            end
          end
        end
        st_payload: begin
          if (xfer_s) begin
            case (slot_r)
              2'd0:    cmd_payload_r[31:0]  <= word_i;
              2'd1:    cmd_payload_r[63:32] <= word_i;
              2'd2:    cmd_payload_r[95:64] <= word_i;
              default: cmd_payload_r        <= cmd_payload_r;
            endcase
            slot_r   <= slot_r + 2'd1;
            remain_r <= remain_r - 7'd1;
            // Drop ready on the last word so nothing is accepted while the command waits.
            if (remain_r == 7'd1) begin
              state_r      <= st_emit;
              word_ready_r <= 1'b0;
              cmd_v_r      <= 1'b1;
            end
          end
        end
        st_emit: begin
          if (cmd_ready_i) begin
            cmd_v_r      <= 1'b0;
            cmd_count_r  <= cmd_count_r + 16'd1;
            word_ready_r <= 1'b1;
            state_r      <= st_idle;
          end
        end
        st_drain: begin
          if (xfer_s) begin
            remain_r <= remain_r - 7'd1;
            if (remain_r == 7'd1) begin
              state_r <= st_idle;
            end
          end
        end
        default: begin
          state_r      <= st_idle;
          word_ready_r <= 1'b0;
          cmd_v_r      <= 1'b0;
        end
      endcase
    end
  end

  assign word_ready_o  = word_ready_r;
  assign cmd_v_o       = cmd_v_r;
  assign cmd_op_o      = cmd_op_r;
  assign cmd_id_o      = cmd_id_r;
  assign cmd_payload_o = cmd_payload_r;
  assign err_v_o       = err_v_r;
  assign err_code_o    = err_code_r;
  assign cmd_count_o   = cmd_count_r;
  assign err_count_o   = err_count_r;

endmodule

// File: doc/cmd_parser.md
CMD_PARSER -- requirements
Module: cmd_parser

Interface
REQ-001 The module SHALL provide the ports listed below; one clock; reset is synchronous and active-high.
- clk_i  in  1  sole clock
- reset_i  in  1  synchronous, active-high reset
- word_v_i  in  1  command-FIFO word valid
- word_i  in  32  command word (cmd_buf_width_gp)
- word_ready_o  out  1  parser accepts word_i this cycle
- cmd_v_o  out  1  decoded command valid
- cmd_ready_i  in  1  downstream (master controller dispatch) accepts the command
- cmd_op_o  out  8  cmd_op_s opcode
- cmd_id_o  out  8  header id
- cmd_payload_o  out  96  payload: word 1 in [31:0], word 2 in [63:32], word 3 in [95:64]; unused words are zero
- err_v_o  out  1  one-cycle error pulse
- err_code_o  out  2  0=none, 1=unknown op, 2=length mismatch
- cmd_count_o  out  16  count of emitted commands, wraps
- err_count_o  out  16  count of errors, wraps

Function
REQ-002 A transfer SHALL occur on a cycle where word_v_i and word_ready_o are both high; cmd handshake occurs where cmd_v_o and cmd_ready_i are both high.
REQ-003 The header word SHALL be decoded as op=[7:0], id=[15:8], len=[23:16] (payload bytes), reserved=[31:24] (ignored).
REQ-004 Expected len per op SHALL be: F0 fetch=8, F1 disp=4, F2 tile=12, F3 wait_disp=4, F4 wait_tile=4.
REQ-005 FSM states SHALL be IDLE, PAYLOAD, EMIT and DRAIN.
REQ-006 IDLE: word_ready_o=1; on a header transfer with a known op and matching len, latch op/id, clear payload, go to PAYLOAD with word count = len/4.
REQ-007 PAYLOAD: word_ready_o=1; store the k-th payload word into slot k; after the last word go to EMIT.
REQ-008 EMIT: word_ready_o=0, cmd_v_o=1; outputs stable until handshake; on handshake increment cmd_count_o and go to IDLE.
REQ-009 Latency: cmd_v_o SHALL rise the cycle after the last payload word transfer. Minimum spacing between commands: one EMIT cycle.
REQ-010 Unknown op (not F0-F4): pulse err_v_o with code 1 the cycle after the header.
REQ-011 Known op with wrong len: pulse err_v_o with code 2 the cycle after the header.
REQ-012 On either error, the parser SHALL go to DRAIN and discard ceil(len/4) words. If len=0, it SHALL return to IDLE. No command is emitted.
REQ-013 DRAIN: word_ready_o=1; return to IDLE after the final discarded word; err_count_o increments once per error.
REQ-014 Input stalls (word_v_i low) in PAYLOAD/DRAIN SHALL hold state and counts without timeout.
REQ-015 Counters SHALL wrap FFFF->0000.
REQ-016 err_code_o SHALL be 0 whenever err_v_o is low.

Reset
REQ-017 While reset_i is high, on each clock: state=IDLE, cmd_v_o=0, err_v_o=0, err_code_o=0, cmd_op_o/cmd_id_o/cmd_payload_o=0, counters=0, word_ready_o=0.
REQ-018 Reset asserted mid-PAYLOAD/EMIT/DRAIN SHALL abandon the partial command without emitting it. The first word accepted after reset SHALL be treated as a header.

Structure
REQ-019 The shared package SHALL hold the expected-len constants per op, a payload-word-count constant (3), a cmd_parse_err_e enum (none/unknown_op/len_mismatch) and a parser-state enum. It SHALL reuse the existing cmd_op_s and cmd_header_s types.
REQ-020 The block SHALL be a single module with no sub-modules. Counters SHALL be inline.

Verification
REQ-021 Fetch: words 0x000805F0, 0x00001000, 0x00010020 -> cmd_v_o next cycle with op=F0, id=05, payload=0x0000_0000_0001_0020_0000_1000; cmd_count_o=1.
REQ-022 Tile with cmd_ready_i low for 5 cycles: header 0x000C07F2 plus 3 words -> outputs held stable and word_ready_o=0 throughout; accepted on cycle 6.
REQ-023 Unknown op 0x0008_01AA + 2 words -> err_v_o pulse with code 1, 2 words dropped, no cmd_v_o. Next header 0x000402F3 + 1 word parses normally.
REQ-024 Length mismatch 0x000403F0 + 1 word -> code 2, 1 word drained; header 0x00000004F4 (len 0) -> code 2, immediate return to IDLE.
REQ-025 Reset pulsed after 1 of 3 tile payload words -> no cmd_v_o. A subsequent fetch sequence is decoded correctly with cmd_count_o=1.
REQ-026 Random word_v_i gaps over 1000 mixed legal commands -> emitted sequence matches the reference model; cmd_count_o=1000 (mod 65536); err_count_o=0.
